// File: rtl/data_ram.sv
// data_ram: word-organised data memory for the MEM stage of a 5-stage RISC-V pipeline.
// Byte address in, combinational read out, synchronous word write on the rising clk edge.
// Asynchronous active-high reset clears every word immediately.
// Optional feature: define DATA_RAM_BYTE_WE_EN to add a 4-bit byte_en port for per-lane writes.
module data_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        we,
`ifdef DATA_RAM_BYTE_WE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] read_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic [3:0]       lane_we;
  logic [31:0]      rd_words [DEPTH_WORDS];
  logic             unused_addr_lsbs;

  // The low two address bits never select anything: accesses are word aligned.
  assign unused_addr_lsbs = ^address[1:0];

  assign word_idx = address[IDX_W+1:2];
  assign in_range = (address[31:IDX_W+2] == '0);

`ifdef DATA_RAM_BYTE_WE_EN
  assign lane_we = byte_en;
`else
  assign lane_we = 4'hF;
`endif

  // Storage is one register per word so the whole array can be cleared
  // asynchronously; this rules out a block RAM mapping.
  for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
    logic        wr_hit;
    logic [31:0] word_q;
    logic [31:0] word_d;

    assign wr_hit = we && in_range && (word_idx == IDX_W'(gi));

    // Merge the enabled byte lanes of the store data into the current word.
    always_comb begin
      word_d = word_q;
      for (int l = 0; l < 4; l++) begin
        if (wr_hit && lane_we[l]) begin
          word_d[8*l +: 8] = write_data[8*l +: 8];
        end
      end
    end

    // Word register: async clear dominates, otherwise capture the merged word.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q <= '0;
      end else begin
        word_q <= word_d;
      end
    end

    assign rd_words[gi] = word_q;
  end

  // Combinational read; addresses above the array return zero rather than aliasing.
  always_comb begin
    read_data = 32'h0;
    if (in_range) begin
      read_data = rd_words[word_idx];
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: directed-vector bench for data_ram with a reference memory model
// and a per-cycle compare process, plus literal expectations for the test plan.
`timescale 1ns/1ps
module tb_data_ram;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        we;
`ifdef DATA_RAM_BYTE_WE_EN
  logic [3:0]  byte_en;
`endif
  logic [31:0] read_data;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // Reference model: 256 words of byte-addressed memory.
  logic [31:0] model_mem [256];

  data_ram dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write_data (write_data),
    .we         (we),
`ifdef DATA_RAM_BYTE_WE_EN
    .byte_en    (byte_en),
`endif
    .read_data  (read_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a >= 32'h400) return 32'h0;
    return model_mem[a / 4];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s addr=%08h got=%08h expected=%08h @%0t", name, address, act, exp, $time);
    end
  endtask

  // Model: asynchronous clear on reset.
  always @(posedge reset) begin
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
  end

  // Model: store on the rising edge when enabled, not in reset, and in range.
  always @(posedge clk) begin
    if (we && !reset && address < 32'h400) begin
      logic [31:0] w;
      logic [3:0]  be;
      w  = model_mem[address / 4];
`ifdef DATA_RAM_BYTE_WE_EN
      be = byte_en;
`else
      be = 4'hF;
`endif
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = write_data[8*b +: 8];
      model_mem[address / 4] = w;
    end
  end

  // Compare process: mid-cycle, the DUT read must match the model.
  always @(negedge clk) begin
    if (cmp_en) check("model", read_data, model_read(address));
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One full store transaction; inputs change 1ns after an edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    address = a; write_data = d; we = 1'b1;
`ifdef DATA_RAM_BYTE_WE_EN
    byte_en = be;
`endif
    @(posedge clk); #1;
    we = 1'b0;
    $display("write addr=%08h data=%08h be=%b", a, d, be);
  endtask

  task automatic read_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, read_data, exp);
    $display("read  addr=%08h data=%08h expected=%08h", a, read_data, exp);
  endtask

  initial begin
    reset = 1'b1; address = 32'h0; write_data = 32'h0; we = 1'b0;
`ifdef DATA_RAM_BYTE_WE_EN
    byte_en = 4'hF;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1;

    // Reset state
    read_lit("reset_state_0x10", 32'h10, 32'h0);
    read_lit("reset_state_0x3fc", 32'h3FC, 32'h0);

    // Write then read
    do_write(32'h20, 32'h12345678, 4'hF);
    read_lit("wr_rd_0x20", 32'h20, 32'h12345678);
    read_lit("wr_rd_0x24", 32'h24, 32'h0);

    // Same-cycle read/write: old value before the edge, new value after
    do_write(32'h08, 32'h11111111, 4'hF);
    @(posedge clk); #1;
    address = 32'h08; write_data = 32'h22222222; we = 1'b1;
    #1 check("same_cycle_before", read_data, 32'h11111111);
    @(posedge clk); #1;
    we = 1'b0;
    check("same_cycle_after", read_data, 32'h22222222);
    $display("rmw   addr=00000008 data=%08h", read_data);

    // Alignment and range
    do_write(32'h30, 32'hCAFEF00D, 4'hF);
    read_lit("misaligned_0x33", 32'h33, 32'hCAFEF00D);
    read_lit("misaligned_0x31", 32'h31, 32'hCAFEF00D);
    do_write(32'h400, 32'h55555555, 4'hF);
    read_lit("oor_0x400", 32'h400, 32'h0);
    read_lit("word0_untouched", 32'h0, 32'h0);
    do_write(32'h8000_0000, 32'h66666666, 4'hF);
    read_lit("oor_high_bit", 32'h8000_0000, 32'h0);
    read_lit("word0_untouched2", 32'h0, 32'h0);

    // Top word boundary, written misaligned
    do_write(32'h3FD, 32'h0BADF00D, 4'hF);
    read_lit("top_word", 32'h3FC, 32'h0BADF00D);

    // we low keeps memory
    do_write(32'h40, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    address = 32'h40; write_data = 32'hFFFFFFFF; we = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("we_low", read_data, 32'hA5A5A5A5);
    $display("hold  addr=00000040 data=%08h", read_data);

    // Directed vector table: model compare process checks these
    for (int i = 0; i < 8; i++) begin
      do_write(32'h100 + i * 4, 32'h01010101 * (i + 1), 4'hF);
      read_lit("vec", 32'h100 + i * 4, 32'h01010101 * (i + 1));
    end

`ifdef DATA_RAM_BYTE_WE_EN
    do_write(32'h50, 32'hAABBCCDD, 4'hF);
    do_write(32'h50, 32'h11223344, 4'b0101);
    read_lit("byte_en_0101", 32'h50, 32'hAA22CC44);
    do_write(32'h50, 32'hFFFFFFFF, 4'b0000);
    read_lit("byte_en_0000", 32'h50, 32'hAA22CC44);
    do_write(32'h50, 32'h99000000, 4'b1000);
    read_lit("byte_en_1000", 32'h50, 32'h9922CC44);
`endif

    // Reset clear between edges, with no clock edge needed
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
    read_lit("pre_reset", 32'h10, 32'hDEADBEEF);
    @(posedge clk); #3;
    reset = 1'b1;
    #1 check("async_reset_0x10", read_data, 32'h0);
    read_lit("async_reset_0x20", 32'h20, 32'h0);
    // Writes are blocked while reset is held
    address = 32'h10; write_data = 32'h77777777; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
    reset = 1'b0;
    read_lit("write_blocked_in_reset", 32'h10, 32'h0);
    @(posedge clk); #1;
    read_lit("after_reset_0x40", 32'h40, 32'h0);

    @(posedge clk); #1;
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
